// File: rtl/sha256_msg_fetch.sv
// Avalon-MM read master streaming 16-word SHA-256 message blocks from on-chip RAM into the hash core.
// Optional `define SHA_FETCH_BSWAP_EN byte-reverses each word (little-endian RAM -> big-endian SHA words).
module sha256_msg_fetch #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_blocks,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last_word,
    output logic              out_last_block
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [7:0]        nblk_reg;
    logic [11:0]       issued_reg;
    logic [11:0]       popped_reg;
    logic              inflight_reg;
    logic              zero_done_reg;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic [11:0]       total_words;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;
    logic              push, pop, final_word, accept_start;
    logic [DATA_W-1:0] push_data;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign total_words = {nblk_reg, 4'b0000};
    assign mem_address = base_reg + ADDR_W'(issued_reg);
    assign busy        = (state_reg != IDLE);

`ifdef SHA_FETCH_BSWAP_EN
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_bswap
            assign push_data[gi*8 +: 8] = mem_readdata[DATA_W-8-gi*8 +: 8];
        end
    endgenerate
`else
    assign push_data = mem_readdata;
`endif

    // RAM data arrives one cycle after its chipselect and is always pushed;
    // the credit check below reserves a slot for every read in flight.
    assign push = inflight_reg;
    assign pop  = out_valid && out_ready;

    assign credit_used = {1'b0, count_reg} + (CNT_W+1)'(inflight_reg) - (CNT_W+1)'(pop);
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    assign out_valid      = (count_reg != '0);
    assign out_data       = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign out_last_word  = out_valid && (popped_reg[3:0] == 4'hF);
    assign out_last_block = out_valid && (popped_reg[11:4] == nblk_reg - 8'd1);
    assign final_word     = out_last_word && out_last_block;

    always_comb begin
        state_next     = state_reg;
        mem_chipselect = 1'b0;
        accept_start   = 1'b0;
        done           = zero_done_reg;
        case (state_reg)
            IDLE: begin
                if (start && (num_blocks != '0)) begin
                    accept_start = 1'b1;
                    state_next   = FETCH;
                end
            end
            FETCH: begin
                mem_chipselect = (issued_reg < total_words) && credit_ok;
                if (mem_chipselect && (issued_reg + 12'd1 == total_words))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && final_word) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            nblk_reg      <= '0;
            issued_reg    <= '0;
            popped_reg    <= '0;
            inflight_reg  <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            inflight_reg  <= mem_chipselect;
            zero_done_reg <= (state_reg == IDLE) && start && (num_blocks == '0);
            if (accept_start) begin
                base_reg   <= base_addr;
                nblk_reg   <= num_blocks;
                issued_reg <= '0;
                popped_reg <= '0;
            end else begin
                if (mem_chipselect)
                    issued_reg <= issued_reg + 12'd1;
                if (pop)
                    popped_reg <= popped_reg + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: doc/sha256_msg_fetch.md
# sha256_msg_fetch

Avalon-MM read master that pulls SHA-256 message blocks out of the 8192 x 32-bit on-chip RAM and streams them, one word per cycle, to the SHA-256 core. It sits directly upstream of the hash core and downstream of the on-chip RAM's read port. The RAM has a 1-cycle read latency: the address is registered and the output is unregistered. The block issues word reads, buffers the returned data in a small FIFO to absorb core backpressure, and tags block and message boundaries.

## Interface
- ADDR_W, 13: word address width; matches the RAM depth of 8192.
- DATA_W, 32: data width.
- FIFO_DEPTH, 4: output buffer depth in words; power of two, at least 2.
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  word address of the first message word.
- num_blocks  in  8  number of 512-bit blocks (16 words each) to fetch.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse when the last word has been accepted downstream.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  read strobe, one word per asserted cycle.
- mem_write  out  1  tied to 0.
- mem_byteenable  out  4  tied to 4'hF.
- mem_clken  out  1  tied to 1.
- mem_readdata  in  DATA_W  RAM data, valid the cycle after its chipselect cycle.
- out_data  out  DATA_W  message word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  core accepts the word; a transfer occurs when out_valid and out_ready are both high.
- out_last_word  out  1  word index 15 of the current block.
- out_last_block  out  1  word belongs to the final block.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE to FETCH: start=1 and num_blocks!=0. base_addr and num_blocks are latched; the issue and pop counters are cleared.
- start with num_blocks==0: no reads are issued. done pulses on the next cycle and the FSM stays in IDLE.
- start while busy is ignored.
- FETCH: mem_chipselect=1 whenever issued < num_blocks*16 and fifo_count + inflight - pop < FIFO_DEPTH.
  - pop = the output handshake in the same cycle.
  - inflight = 1 if chipselect was high in the previous cycle, otherwise 0.
- mem_address = (base_addr + issued) mod 2^ADDR_W; the address wraps from 8191 to 0.
- issued is a 12-bit counter; the maximum is 255*16 = 4080.
- FETCH to DRAIN: the cycle after the final read is issued.
- DRAIN to IDLE: when the final word's handshake occurs. done pulses in that same cycle and busy falls in the next cycle.
- The return data from each read is pushed into the FIFO unconditionally; the credit check guarantees the FIFO never overflows.
- out_last_word and out_last_block are derived from a popped-word counter: index[3:0]==15, and block index == num_blocks-1.
- Data order is strictly address order. No words are dropped or duplicated.

## Timing
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_data=0, out_last_word=0, out_last_block=0. The FIFO and all counters are cleared.
- Reset mid-operation: returns to IDLE on the next edge. Any in-flight read return is discarded. No done pulse is generated.
- start sampled at edge 0 produces:
  - first mem_chipselect in cycle 1;
  - data captured at the end of cycle 2;
  - out_valid high in cycle 3.
- With out_ready held at 1, throughput is 1 word per cycle. Latency from start to done for N blocks is 16N+3 cycles.
- out_ready=0: mem_chipselect stops once the credit check fails, within at most FIFO_DEPTH outstanding words. out_data and the tags hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.

## Configuration
- SHA_FETCH_BSWAP_EN defined: out_data is the byte-reversed mem_readdata, i.e. {b0,b1,b2,b3}. This converts little-endian CPU-written messages to SHA-256 big-endian words. There is no extra latency.
- SHA_FETCH_BSWAP_EN undefined: out_data equals mem_readdata unchanged.

## Test plan
- Single block: base_addr=0x010, num_blocks=1, RAM[0x10+i]=i, out_ready=1.
  - Expected: 16 words 0..15 on cycles 3..18.
  - out_last_word and out_last_block are high only on word 15.
  - done on cycle 18; 16N+3=19 cycles from start to done.
- Wrap-around: base_addr=0x1FF8, num_blocks=1.
  - Expected: reads of addresses 0x1FF8..0x1FFF then 0x0000..0x0007, data in that order, no stray accesses.
- Backpressure: num_blocks=3 with out_ready randomly toggled at 50%.
  - Expected: 48 words in order.
  - out_last_word fires 3 times; out_last_block is set on words 32..47.
  - Never more than FIFO_DEPTH words are outstanding or buffered.
- Zero-length and busy-start: num_blocks=0 gives a done pulse 1 cycle later with no chipselect. A second start during a 2-block run is ignored and exactly 32 words are delivered.
- Reset mid-operation: assert reset for 1 cycle at word 7 of block 0.
  - Expected: outputs at reset values next cycle, no done pulse, no further chipselect.
  - A new start afterwards delivers a clean block from the new base_addr.
- Endian swap with SHA_FETCH_BSWAP_EN: RAM word 0x61626380 appears as out_data 0x80636261. Without the macro it appears as 0x61626380.
